ext_mem_host: RTL and testbench

- Host-side initiator for the CPU's external memory back-door ports.
- Accepts commands over a valid/ready stream: load words into instruction memory, load or read data memory, read back instruction memory, and run the core for N cycles.
- Drives the instruction-memory ext port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext), the data-memory ext port (the *_2 set) and the CPU enable input.
- Sits between the testbench/debug host and the cpu top.

---
 rtl/ext_mem_host_pkg.sv | 42 ++++
 rtl/ext_mem_host_run_ctr.sv | 28 ++
 rtl/ext_mem_host.sv | 193 +++++++++++++++++++
 tb/tb_ext_mem_host.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_host_pkg.sv
// Shared types for the external-memory host initiator.
// Op encodings, FSM states and the registered output bundle.
package ext_mem_host_pkg;

  localparam int EXT_ADDR_W  = 64;
  localparam int IMEM_DATA_W = 32;
  localparam int DMEM_DATA_W = 64;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_IMEM_WR = 3'd1;
  localparam logic [2:0] OP_IMEM_RD = 3'd2;
  localparam logic [2:0] OP_DMEM_WR = 3'd3;
  localparam logic [2:0] OP_DMEM_RD = 3'd4;
  localparam logic [2:0] OP_RUN     = 3'd5;
  localparam logic [2:0] OP_CNT_RD  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT,
    S_RUN,
    S_RESP
  } state_t;

  typedef struct packed {
    logic                   cmd_ready;
    logic                   rsp_valid;
    logic [63:0]            rsp_data;
    logic                   busy;
    logic                   cpu_enable;
    logic [EXT_ADDR_W-1:0]  imem_addr;
    logic                   imem_wen;
    logic                   imem_ren;
    logic [IMEM_DATA_W-1:0] imem_wdata;
    logic [EXT_ADDR_W-1:0]  dmem_addr;
    logic                   dmem_wen;
    logic                   dmem_ren;
    logic [DMEM_DATA_W-1:0] dmem_wdata;
  } host_out_t;

endpackage

// File: rtl/ext_mem_host_run_ctr.sv
// Loadable down-counter with a terminal flag at 1.
// Shared by the read-latency wait and the run-length count.
module ext_mem_host_run_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/ext_mem_host.sv
// Host initiator driving the CPU imem/dmem back-door ports and enable.
// Optional run-cycle counter: define EXT_MEM_HOST_CYCLE_CNT_EN.
module ext_mem_host
  import ext_mem_host_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);

  state_t           state, state_d;
  host_out_t        o, o_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cmd_len, ld_val;
  logic             ld, dec, term;
  logic [63:0]      cyc_cnt;
  logic             is_wr, is_rd, is_run, is_cnt, is_imem;

  assign cmd_len = cmd_data[CNT_W-1:0];
  assign is_wr   = (cmd_op == OP_IMEM_WR) || (cmd_op == OP_DMEM_WR);
  assign is_rd   = (cmd_op == OP_IMEM_RD) || (cmd_op == OP_DMEM_RD);
  assign is_run  = (cmd_op == OP_RUN);
  assign is_cnt  = (cmd_op == OP_CNT_RD);
  assign is_imem = (cmd_op == OP_IMEM_WR) || (cmd_op == OP_IMEM_RD);

  ext_mem_host_run_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .term     (term)
  );

`ifdef EXT_MEM_HOST_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cyc_cnt <= '0;
    end else if (o.cpu_enable && !(&cyc_cnt)) begin
      cyc_cnt <= cyc_cnt + 64'd1;
    end
  end
`else
  assign cyc_cnt = '0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      o           <= '0;
      o.cmd_ready <= 1'b1;
      op_q        <= OP_NOP;
      len_q       <= '0;
    end else begin
      state <= state_d;
      o     <= o_d;
      op_q  <= op_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    state_d      = state;
    o_d          = o;
    op_d         = op_q;
    len_d        = len_q;
    o_d.cpu_enable = 1'b0;
    o_d.imem_wen = 1'b0;
    o_d.imem_ren = 1'b0;
    o_d.dmem_wen = 1'b0;
    o_d.dmem_ren = 1'b0;
    ld           = 1'b0;
    ld_val       = '0;
    dec          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          len_d = cmd_len;
          unique case (1'b1)
            is_wr: begin
              state_d = S_WR;
              if (is_imem) begin
                o_d.imem_wen   = 1'b1;
                o_d.imem_addr  = cmd_addr;
                o_d.imem_wdata = cmd_data[31:0];
              end else begin
                o_d.dmem_wen   = 1'b1;
                o_d.dmem_addr  = cmd_addr;
                o_d.dmem_wdata = cmd_data;
              end
            end
            is_rd: begin
              state_d = S_RD;
              if (is_imem) begin
                o_d.imem_ren  = 1'b1;
                o_d.imem_addr = cmd_addr;
              end else begin
                o_d.dmem_ren  = 1'b1;
                o_d.dmem_addr = cmd_addr;
              end
            end
            is_run: begin
              if (cmd_len != '0) begin
                state_d        = S_RUN;
                o_d.cpu_enable = 1'b1;
                ld             = 1'b1;
                ld_val         = cmd_len;
              end else begin
                state_d      = S_RESP;
                o_d.rsp_data = '0;
              end
            end
            is_cnt: begin
              state_d      = S_RESP;
              o_d.rsp_data = cyc_cnt;
            end
            default: ;
          endcase
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD: begin
        state_d = S_WAIT;
        ld      = 1'b1;
        ld_val  = CNT_W'(RD_LAT);
      end
      S_WAIT: begin
        dec = 1'b1;
        if (term) begin
          state_d      = S_RESP;
          o_d.rsp_data = (op_q == OP_IMEM_RD) ? 64'(rdata_ext)
                                               : rdata_ext_2;
        end
      end
      S_RUN: begin
        dec = 1'b1;
        // Counter at 1 marks the last enabled cycle.
        if (term) begin
          state_d      = S_RESP;
          o_d.rsp_data = 64'(len_q);
        end else begin
          o_d.cpu_enable = 1'b1;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    o_d.cmd_ready = (state_d == S_IDLE);
    o_d.rsp_valid = (state_d == S_RESP);
    o_d.busy      = (state_d != S_IDLE);
  end

  assign cmd_ready   = o.cmd_ready;
  assign rsp_valid   = o.rsp_valid;
  assign rsp_data    = o.rsp_data;
  assign busy        = o.busy;
  assign cpu_enable  = o.cpu_enable;
  assign addr_ext    = o.imem_addr;
  assign wen_ext     = o.imem_wen;
  assign ren_ext     = o.imem_ren;
  assign wdata_ext   = o.imem_wdata;
  assign addr_ext_2  = o.dmem_addr;
  assign wen_ext_2   = o.dmem_wen;
  assign ren_ext_2   = o.dmem_ren;
  assign wdata_ext_2 = o.dmem_wdata;

endmodule

// File: tb/tb_ext_mem_host.sv
// Directed + randomized bench for ext_mem_host with SRAM models
// and a byte-address reference map for expected read data.
module tb_ext_mem_host;

  localparam int RD_LAT = 1;
  localparam int CNT_W  = 32;

  localparam logic [2:0] C_NOP = 3'd0, C_IWR = 3'd1, C_IRD = 3'd2;
  localparam logic [2:0] C_DWR = 3'd3, C_DRD = 3'd4, C_RUN = 3'd5;
  localparam logic [2:0] C_CNT = 3'd6, C_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        busy, cpu_enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext, rdata_ext;

  int errors = 0;
  int checks = 0;
  longint unsigned exp_cyc = 0;

  logic [31:0] ref_i [logic [63:0]];
  logic [63:0] ref_d [logic [63:0]];

  always #5 clk = ~clk;

  ext_mem_host #(
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  // Synchronous SRAMs with RD_LAT-deep read pipes.
  logic [31:0] sram_i [0:255];
  logic [63:0] sram_d [0:127];
  logic [31:0] pipe_i [RD_LAT];
  logic [63:0] pipe_d [RD_LAT];

  initial begin
    for (int k = 0; k < 256; k++) sram_i[k] = '0;
    for (int k = 0; k < 128; k++) sram_d[k] = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      pipe_i[k] = '0;
      pipe_d[k] = '0;
    end
  end

  always @(posedge clk) begin
    if (wen_ext) sram_i[addr_ext[9:2]] <= wdata_ext;
    if (wen_ext_2) sram_d[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext) pipe_i[0] <= sram_i[addr_ext[9:2]];
    if (ren_ext_2) pipe_d[0] <= sram_d[addr_ext_2[9:3]];
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_i[k] <= pipe_i[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
  end

  assign rdata_ext   = pipe_i[RD_LAT-1];
  assign rdata_ext_2 = pipe_d[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("ready_back", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_write(input bit imem, input logic [63:0] a,
                          input logic [63:0] d);
    int extra;
    send(imem ? C_IWR : C_DWR, a, d);
    if (imem) begin
      check("imem_wen", 64'(wen_ext), 64'd1);
      check("imem_addr", addr_ext, a);
      check("imem_wdata", 64'(wdata_ext), 64'(d[31:0]));
      ref_i[a] = d[31:0];
    end else begin
      check("dmem_wen", 64'(wen_ext_2), 64'd1);
      check("dmem_addr", addr_ext_2, a);
      check("dmem_wdata", wdata_ext_2, d);
      ref_d[a] = d;
    end
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wen_ext || wen_ext_2 || rsp_valid) extra++;
    end
    check("wr_single_pulse_no_rsp", 64'(extra), 64'd0);
  endtask

  task automatic do_read(input bit imem, input logic [63:0] a,
                         output logic [63:0] exp);
    int n;
    if (imem) exp = ref_i.exists(a) ? 64'(ref_i[a]) : 64'd0;
    else      exp = ref_d.exists(a) ? ref_d[a] : 64'd0;
    send(imem ? C_IRD : C_DRD, a, 64'd0);
    check("rd_ren", 64'(imem ? ren_ext : ren_ext_2), 64'd1);
    check("rd_addr", imem ? addr_ext : addr_ext_2, a);
    check("rd_busy", 64'(busy), 64'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_latency", 64'(n), 64'(RD_LAT + 1));
    check("rd_data", rsp_data, exp);
    check("rd_no_cmd_ready", 64'(cmd_ready), 64'd0);
  endtask

  task automatic do_run(input int len);
    int en, bad, k;
    send(C_RUN, 64'd0, 64'(len));
    en = 0;
    bad = 0;
    k = 0;
    while (!rsp_valid && k < len + 20) begin
      if (cpu_enable) en++;
      if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) bad++;
      @(negedge clk);
      k++;
    end
    check("run_enable_cycles", 64'(en), 64'(len));
    check("run_no_mem_access", 64'(bad), 64'd0);
    check("run_rsp_valid", 64'(rsp_valid), 64'd1);
    check("run_rsp_data", rsp_data, 64'(len));
    exp_cyc += longint'(len);
    consume();
    check("run_enable_off", 64'(cpu_enable), 64'd0);
  endtask

  logic [63:0] exp_v, wa, wd, exp_cnt;
  logic [63:0] waddr_q[$];
  bit          wimem_q[$];
  int          stray;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}),
          64'd0);
    check("rst_addr", addr_ext | addr_ext_2, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    arst_n = 1'b1;
    @(negedge clk);

    do_write(1'b1, 64'h8, 64'h0050_0093);
    do_write(1'b0, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    do_read(1'b0, 64'h10, exp_v);
    check("dmem_rd_known", rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
    consume();
    do_read(1'b1, 64'h8, exp_v);
    consume();

    // NOP and reserved op produce no response and no activity.
    send(C_NOP, 64'h20, 64'h1);
    send(C_RSV, 64'h24, 64'h2);
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid || busy || !cmd_ready || wen_ext || wen_ext_2)
        stray++;
      @(negedge clk);
    end
    check("nop_rsv_silent", 64'(stray), 64'd0);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        wa = 64'($urandom_range(0, 255)) << 2;
        wd = {$urandom, $urandom};
        do_write(1'b1, wa, wd);
        wimem_q.push_back(1'b1);
      end else begin
        wa = 64'($urandom_range(0, 127)) << 3;
        wd = {$urandom, $urandom};
        do_write(1'b0, wa, wd);
        wimem_q.push_back(1'b0);
      end
      waddr_q.push_back(wa);
    end
    foreach (waddr_q[k]) begin
      do_read(wimem_q[k], waddr_q[k], exp_v);
      consume();
    end
    do_read(1'b0, 64'h3F8, exp_v);
    consume();

    // Response held under back-pressure; queued command waits.
    do_read(1'b1, waddr_q[0][9:0] & 10'h3FC, exp_v);
    wd = 64'($urandom);
    cmd_valid = 1'b1;
    cmd_op    = C_IWR;
    cmd_addr  = 64'h40;
    cmd_data  = wd;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== exp_v || cmd_ready || wen_ext)
        stray++;
    end
    check("hold_stable", 64'(stray), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_released", 64'(rsp_valid), 64'd0);
    check("hold_ready", 64'(cmd_ready), 64'd1);
    check("hold_not_yet_accepted", 64'(wen_ext), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("queued_wen", 64'(wen_ext), 64'd1);
    check("queued_addr", addr_ext, 64'h40);
    ref_i[64'h40] = wd[31:0];
    @(negedge clk);
    do_read(1'b1, 64'h40, exp_v);
    consume();

    do_run(7);
    do_run(0);
    for (int k = 0; k < 3; k++) do_run(int'($urandom_range(1, 20)));

    // Reset in the third cycle of a long run.
    send(C_RUN, 64'd0, 64'd100);
    repeat (2) @(negedge clk);
    check("run_active_pre_rst", 64'(cpu_enable), 64'd1);
    #1 arst_n = 1'b0;
    #1;
    check("arst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_cyc = 0;
    @(negedge clk);
    arst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_enable || rsp_valid || !cmd_ready || busy) stray++;
    end
    check("post_rst_idle", 64'(stray), 64'd0);

    do_run(7);
    do_run(5);
`ifdef EXT_MEM_HOST_CYCLE_CNT_EN
    exp_cnt = exp_cyc;
`else
    exp_cnt = 64'd0;
`endif
    send(C_CNT, 64'd0, 64'd0);
    check("cnt_rsp_valid", 64'(rsp_valid), 64'd1);
    check("cnt_rd_value", rsp_data, exp_cnt);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
